// File: rtl/prefix_sum_stage_if.sv
// Handshake bundle for prefix_sum_stage: input (t, c) pairs and result output.
// Macro PREFIX_SUM_OVERFLOW_EN adds the out_ovf result field.
interface prefix_sum_stage_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N:1]               in_t;
  logic [N:0]               in_c;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0]             out_sum;
  logic                     out_cout;
  logic                     out_zero;
  logic [$clog2(DEPTH):0]   count;
`ifdef PREFIX_SUM_OVERFLOW_EN
  logic                     out_ovf;
`endif

  modport master (
    output in_valid, in_t, in_c, out_ready,
`ifdef PREFIX_SUM_OVERFLOW_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_cout, out_zero, count
  );

  modport slave (
    input  in_valid, in_t, in_c, out_ready,
`ifdef PREFIX_SUM_OVERFLOW_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_cout, out_zero, count
  );
endinterface

// File: rtl/prefix_sum_stage.sv
// Final sum/carry-out/zero stage of the prefix adder, buffered in a DEPTH-entry result FIFO.
// Macro PREFIX_SUM_OVERFLOW_EN stores and presents a signed-overflow flag per entry.
module prefix_sum_stage #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  prefix_sum_stage_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [N-1:0] sum_mem  [DEPTH];
  logic         cout_mem [DEPTH];
  logic         zero_mem [DEPTH];

  logic [N-1:0] sum_in;
  logic         push, pop;
  logic         in_ready, out_valid;

  // Carry into bit k combines with the half-sum of bit k (stored one index up in in_t).
  assign sum_in    = bus.in_t ^ bus.in_c[N-1:0];
  assign in_ready  = (count_q != Full);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared on reset; out_valid gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr_q]  <= sum_in;
      cout_mem[wr_ptr_q] <= bus.in_c[N];
      zero_mem[wr_ptr_q] <= ~|sum_in;
    end
  end

`ifdef PREFIX_SUM_OVERFLOW_EN
  logic ovf_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) ovf_mem[wr_ptr_q] <= bus.in_c[N] ^ bus.in_c[N-1];
  end

  assign bus.out_ovf = out_valid & ovf_mem[rd_ptr_q];
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.out_sum   = out_valid ? sum_mem[rd_ptr_q] : '0;
  assign bus.out_cout  = out_valid & cout_mem[rd_ptr_q];
  assign bus.out_zero  = out_valid & zero_mem[rd_ptr_q];
endmodule
